// File: rtl/cl_imem_boot_loader.sv
// rtl/cl_imem_boot_loader.sv - DDR-to-IMEM boot loader: AXI4 burst reads unpacked into 32-bit IMEM writes.
// Releases the downstream core from reset once the whole image has been written.
module cl_imem_boot_loader #(
    parameter int          ADDR_W    = 64,
    parameter int          DATA_W    = 512,
    parameter int          IMEM_AW   = 14,
    parameter int          MAX_BURST = 16,
    parameter logic [15:0] AXI_ID    = 16'h0
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [IMEM_AW:0]    word_cnt,
    output logic [ADDR_W-1:0]   araddr,
    output logic [7:0]          arlen,
    output logic [15:0]         arid,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic                imem_we,
    output logic [IMEM_AW-1:0]  imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst_n,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int WC_W = IMEM_AW + 1;
    localparam int BW   = IMEM_AW - 2;
    localparam logic [BW-1:0] MB = BW'(MAX_BURST);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic                start_q, start_d;
    logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BW-1:0]       beats_left_q, beats_left_d;
    logic [BW-1:0]       beats_issued_q, beats_issued_d;
    logic [7:0]          cur_len_q, cur_len_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic                got_last_q, got_last_d;
    logic                err_pend_q, err_pend_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                buf_vld_q, buf_vld_d;
    logic [3:0]          buf_idx_q, buf_idx_d;
    logic [WC_W-1:0]     wr_idx_q, wr_idx_d;

    logic                trig;
    logic                last_word;
    logic                accept;
    logic                beat_err;
    logic [WC_W:0]       wc_round;
    logic [BW-1:0]       beats_init;
    logic [BW-1:0]       burst_beats;

    assign trig        = start & ~start_q;
    assign wc_round    = {1'b0, word_cnt} + (WC_W+1)'(15);
    assign beats_init  = wc_round[WC_W:4];
    assign burst_beats = (beats_left_q > MB) ? MB : beats_left_q;

    assign arvalid = (state_q == ADDR);
    assign arlen   = arvalid ? 8'(burst_beats - BW'(1)) : 8'd0;
    assign araddr  = arvalid ? (base_q + (ADDR_W'(beats_issued_q) << 6)) : '0;
    assign arid    = AXI_ID;
    assign arsize  = 3'd6;

    // Word is final when the beat is exhausted or the image ends inside it.
    assign last_word = buf_vld_q & ((buf_idx_q == 4'd15) | ((wr_idx_q + WC_W'(1)) == word_cnt_q));
    // rready depends only on registered state, never on rvalid.
    assign rready    = (state_q == DATA) & ~got_last_q & (err_pend_q | ~buf_vld_q | last_word);
    assign accept    = rvalid & rready;
    assign beat_err  = (rresp != 2'b00) | (rlast != (beat_cnt_q == cur_len_q));

    assign imem_we    = (state_q == DATA) & buf_vld_q & ~err_pend_q;
    assign imem_addr  = wr_idx_q[IMEM_AW-1:0];
    assign imem_wdata = buf_q[31:0];

    assign busy       = (state_q == ADDR) | (state_q == DATA);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign core_rst_n = (state_q == DONE);

    always_comb begin
        state_d        = state_q;
        start_d        = start;
        word_cnt_d     = word_cnt_q;
        base_d         = base_q;
        beats_left_d   = beats_left_q;
        beats_issued_d = beats_issued_q;
        cur_len_d      = cur_len_q;
        beat_cnt_d     = beat_cnt_q;
        got_last_d     = got_last_q;
        err_pend_d     = err_pend_q;
        buf_d          = buf_q;
        buf_vld_d      = buf_vld_q;
        buf_idx_d      = buf_idx_q;
        wr_idx_d       = wr_idx_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (trig) begin
                    word_cnt_d     = word_cnt;
                    base_d         = base_addr;
                    beats_left_d   = beats_init;
                    beats_issued_d = '0;
                    wr_idx_d       = '0;
                    err_pend_d     = 1'b0;
                    buf_vld_d      = 1'b0;
                    got_last_d     = 1'b0;
                    state_d        = (word_cnt == '0) ? DONE : ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    beats_left_d   = beats_left_q - burst_beats;
                    beats_issued_d = beats_issued_q + burst_beats;
                    cur_len_d      = arlen;
                    beat_cnt_d     = 8'd0;
                    got_last_d     = 1'b0;
                    state_d        = DATA;
                end
            end
            DATA: begin
                if (imem_we) begin
                    wr_idx_d  = wr_idx_q + WC_W'(1);
                    buf_d     = buf_q >> 32;
                    buf_idx_d = buf_idx_q + 4'd1;
                    if (last_word) begin
                        buf_vld_d = 1'b0;
                        if (got_last_q) begin
                            state_d = (beats_left_q == '0) ? DONE : ADDR;
                        end
                    end
                end
                // A new beat may land in the same cycle the previous one drains.
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (err_pend_q | beat_err) begin
                        err_pend_d = 1'b1;
                        buf_vld_d  = 1'b0;
                        if (rlast) begin
                            state_d = ERR;
                        end
                    end else begin
                        buf_d      = rdata;
                        buf_vld_d  = 1'b1;
                        buf_idx_d  = 4'd0;
                        got_last_d = rlast;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_q        <= IDLE;
            start_q        <= 1'b0;
            word_cnt_q     <= '0;
            base_q         <= '0;
            beats_left_q   <= '0;
            beats_issued_q <= '0;
            cur_len_q      <= 8'd0;
            beat_cnt_q     <= 8'd0;
            got_last_q     <= 1'b0;
            err_pend_q     <= 1'b0;
            buf_q          <= '0;
            buf_vld_q      <= 1'b0;
            buf_idx_q      <= 4'd0;
            wr_idx_q       <= '0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            word_cnt_q     <= word_cnt_d;
            base_q         <= base_d;
            beats_left_q   <= beats_left_d;
            beats_issued_q <= beats_issued_d;
            cur_len_q      <= cur_len_d;
            beat_cnt_q     <= beat_cnt_d;
            got_last_q     <= got_last_d;
            err_pend_q     <= err_pend_d;
            buf_q          <= buf_d;
            buf_vld_q      <= buf_vld_d;
            buf_idx_q      <= buf_idx_d;
            wr_idx_q       <= wr_idx_d;
        end
    end

endmodule

// File: tb/tb_cl_imem_boot_loader.sv
// tb/tb_cl_imem_boot_loader.sv - directed bench for cl_imem_boot_loader with an in-bench AXI read responder.
module tb_cl_imem_boot_loader;

    localparam logic [63:0] BASE = 64'h0000_0001_2340_0000;

    logic         clk = 1'b0;
    logic         rst_main_n;
    logic         start;
    logic [63:0]  base_addr;
    logic [14:0]  word_cnt;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [15:0]  arid;
    logic [2:0]   arsize;
    logic         arvalid;
    logic         arready;
    logic [511:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         imem_we;
    logic [13:0]  imem_addr;
    logic [31:0]  imem_wdata;
    logic         core_rst_n;
    logic         busy;
    logic         done;
    logic         err;

    cl_imem_boot_loader dut (
        .clk_main_a0(clk), .rst_main_n(rst_main_n), .start(start),
        .base_addr(base_addr), .word_cnt(word_cnt),
        .araddr(araddr), .arlen(arlen), .arid(arid), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_wr, bad_wr, n_bursts, n_beats, last_we_cyc, end_cyc, first_ar_cyc, timed_out;
    logic c1_core_rst_n, c1_busy;
    logic [63:0] b_addr [0:7];
    logic [7:0]  b_len  [0:7];
    logic [31:0] dbase;

    function automatic logic [511:0] mk_beat(input int g);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = dbase + 32'(g*16 + k);
        return v;
    endfunction

    // Drives a fresh start edge, then acts as the DDR read slave until done/err or max_cyc.
    task automatic run_load(input int wc, input int ar_dly, input int err_beat,
                            input int toggle_at, input int max_cyc, input bit want_end);
        int pend, cur_g, wait_cnt, cyc;
        n_wr = 0; bad_wr = 0; n_bursts = 0; n_beats = 0;
        last_we_cyc = -1; end_cyc = -1; first_ar_cyc = -1; timed_out = 0;
        pend = 0; cur_g = 0; wait_cnt = 0; cyc = 0;
        @(negedge clk);
        start = 1'b0; word_cnt = 15'(wc); base_addr = BASE;
        @(negedge clk);
        start = 1'b1;
        while (cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            arready = 1'b0;
            if (cyc == 1) begin
                c1_core_rst_n = core_rst_n;
                c1_busy = busy;
            end
            if (imem_we) begin
                if (imem_addr !== 14'(n_wr) || imem_wdata !== dbase + 32'(n_wr)) bad_wr++;
                n_wr++;
                last_we_cyc = cyc;
            end
            if (done || err) begin
                end_cyc = cyc;
                break;
            end
            if (cyc == toggle_at) start = 1'b0;
            if (cyc == toggle_at + 1) start = 1'b1;
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            if (pend > 0) begin
                rvalid = 1'b1;
                rdata  = mk_beat(cur_g);
                rlast  = (pend == 1);
                rresp  = (cur_g == err_beat) ? 2'd2 : 2'd0;
                if (rready) begin
                    pend--; cur_g++; n_beats++;
                end
            end
            if (arvalid && pend == 0) begin
                if (first_ar_cyc < 0) first_ar_cyc = cyc;
                if (wait_cnt < ar_dly) begin
                    wait_cnt++;
                end else begin
                    arready = 1'b1;
                    if (n_bursts < 8) begin
                        b_addr[n_bursts] = araddr;
                        b_len[n_bursts]  = arlen;
                    end
                    n_bursts++;
                    pend = int'(arlen) + 1;
                    cur_g = int'((araddr - BASE) >> 6);
                    wait_cnt = 0;
                end
            end
        end
        if (want_end && end_cyc < 0) timed_out = 1;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic test_reset();
        rst_main_n = 1'b0; start = 1'b0; base_addr = BASE; word_cnt = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        repeat (3) @(negedge clk);
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %0b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %0b expected 0", rready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %0b expected 0", imem_we); end
        checks++; if ({core_rst_n, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", {core_rst_n, busy, done, err}); end
        checks++; if (araddr !== 64'd0 || arlen !== 8'd0) begin errors++; $display("FAIL reset_ar: got %h/%0d expected 0/0", araddr, arlen); end
        checks++; if (imem_addr !== 14'd0) begin errors++; $display("FAIL reset_imem_addr: got %0d expected 0", imem_addr); end
        checks++; if (arsize !== 3'd6 || arid !== 16'h0) begin errors++; $display("FAIL reset_const: got %0d/%h expected 6/0", arsize, arid); end
        rst_main_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        dbase = 32'h0;
        run_load(0, 0, -1, -1, 10, 1);
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL zero_done: got %0b/%0b expected 1/1", done, core_rst_n); end
        checks++; if (end_cyc < 1 || end_cyc > 2) begin errors++; $display("FAIL zero_latency: got %0d expected 1..2", end_cyc); end
        checks++; if (n_bursts !== 0) begin errors++; $display("FAIL zero_no_ar: got %0d expected 0", n_bursts); end
    endtask

    task automatic test_small_load();
        dbase = 32'h11;
        run_load(5, 0, -1, -1, 200, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL small_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_wr !== 5 || bad_wr !== 0) begin errors++; $display("FAIL small_writes: got %0d writes %0d bad expected 5 writes 0 bad", n_wr, bad_wr); end
        checks++; if (n_bursts !== 1 || b_len[0] !== 8'd0 || b_addr[0] !== BASE) begin errors++; $display("FAIL small_ar: got %0d bursts len %0d addr %h expected 1 len 0 addr %h", n_bursts, b_len[0], b_addr[0], BASE); end
        checks++; if (first_ar_cyc < 1 || first_ar_cyc > 2) begin errors++; $display("FAIL small_ar_latency: got %0d expected 1..2", first_ar_cyc); end
        checks++; if (end_cyc - last_we_cyc !== 1) begin errors++; $display("FAIL small_done_latency: got %0d expected 1", end_cyc - last_we_cyc); end
        checks++; if ({done, core_rst_n, busy, err} !== 4'b1100) begin errors++; $display("FAIL small_status: got %b expected 1100", {done, core_rst_n, busy, err}); end
    endtask

    task automatic test_multi_burst();
        dbase = 32'hA000_0000;
        run_load(600, 3, -1, -1, 2000, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL multi_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_bursts !== 3) begin errors++; $display("FAIL multi_nbursts: got %0d expected 3", n_bursts); end
        checks++; if (b_len[0] !== 8'd15 || b_len[1] !== 8'd15 || b_len[2] !== 8'd5) begin errors++; $display("FAIL multi_arlen: got %0d,%0d,%0d expected 15,15,5", b_len[0], b_len[1], b_len[2]); end
        checks++; if (b_addr[0] !== BASE || b_addr[1] !== BASE + 64'h400 || b_addr[2] !== BASE + 64'h800) begin errors++; $display("FAIL multi_araddr: got %h,%h,%h expected base,+400,+800", b_addr[0], b_addr[1], b_addr[2]); end
        checks++; if (n_wr !== 600 || bad_wr !== 0) begin errors++; $display("FAIL multi_writes: got %0d writes %0d bad expected 600 writes 0 bad", n_wr, bad_wr); end
        checks++; if (n_beats !== 38) begin errors++; $display("FAIL multi_beats: got %0d expected 38", n_beats); end
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL multi_done: got %0b/%0b expected 1/1", done, core_rst_n); end
    endtask

    task automatic test_rresp_error();
        dbase = 32'h5000_0000;
        run_load(256, 0, 3, -1, 2000, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL err_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_wr !== 48 || bad_wr !== 0) begin errors++; $display("FAIL err_writes: got %0d writes %0d bad expected 48 writes 0 bad", n_wr, bad_wr); end
        checks++; if (n_beats !== 16) begin errors++; $display("FAIL err_drain: got %0d beats expected 16", n_beats); end
        checks++; if ({err, core_rst_n, done, busy} !== 4'b1000) begin errors++; $display("FAIL err_status: got %b expected 1000", {err, core_rst_n, done, busy}); end
        repeat (3) @(negedge clk);
        checks++; if (err !== 1'b1 || rready !== 1'b0) begin errors++; $display("FAIL err_hold: got %0b/%0b expected 1/0", err, rready); end
        run_load(40, 0, -1, -1, 500, 1);
        checks++; if (done !== 1'b1 || err !== 1'b0 || n_wr !== 40 || bad_wr !== 0) begin errors++; $display("FAIL err_recover: got done %0b err %0b writes %0d bad %0d expected 1 0 40 0", done, err, n_wr, bad_wr); end
    endtask

    task automatic test_start_edges();
        dbase = 32'h7700_0000;
        run_load(600, 0, -1, 40, 2000, 1);
        checks++; if (n_wr !== 600 || bad_wr !== 0 || n_bursts !== 3) begin errors++; $display("FAIL edge_toggle: got %0d writes %0d bad %0d bursts expected 600 0 3", n_wr, bad_wr, n_bursts); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL edge_toggle_done: got %0b expected 1", done); end
        repeat (5) @(negedge clk);
        checks++; if (done !== 1'b1 || arvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL edge_held: got done %0b arvalid %0b busy %0b expected 1 0 0", done, arvalid, busy); end
        run_load(32, 0, -1, -1, 500, 1);
        checks++; if (c1_core_rst_n !== 1'b0 || c1_busy !== 1'b1) begin errors++; $display("FAIL edge_reload: got core_rst_n %0b busy %0b expected 0 1", c1_core_rst_n, c1_busy); end
        checks++; if (n_wr !== 32 || bad_wr !== 0 || done !== 1'b1) begin errors++; $display("FAIL edge_reload_done: got %0d writes %0d bad done %0b expected 32 0 1", n_wr, bad_wr, done); end
    endtask

    task automatic test_async_reset();
        dbase = 32'h3300_0000;
        run_load(600, 0, -1, -1, 30, 0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_midload: got busy %0b expected 1", busy); end
        #2;
        start = 1'b0;
        rst_main_n = 1'b0;
        #1;
        checks++; if ({arvalid, rready, imem_we, busy, done, err, core_rst_n} !== 7'd0) begin errors++; $display("FAIL arst_outputs: got %b expected 0000000", {arvalid, rready, imem_we, busy, done, err, core_rst_n}); end
        checks++; if (araddr !== 64'd0 || imem_addr !== 14'd0) begin errors++; $display("FAIL arst_addr: got %h/%0d expected 0/0", araddr, imem_addr); end
        @(negedge clk);
        rst_main_n = 1'b1;
        run_load(20, 0, -1, -1, 500, 1);
        checks++; if (done !== 1'b1 || n_wr !== 20 || bad_wr !== 0 || timed_out !== 0) begin errors++; $display("FAIL arst_reload: got done %0b writes %0d bad %0d timeout %0d expected 1 20 0 0", done, n_wr, bad_wr, timed_out); end
    endtask

    task automatic test_full_imem();
        dbase = 32'hC000_0000;
        run_load(16384, 0, -1, -1, 20000, 1);
        checks++; if (timed_out !== 0) begin errors++; $display("FAIL full_timeout: got %0d expected 0", timed_out); end
        checks++; if (n_wr !== 16384 || bad_wr !== 0) begin errors++; $display("FAIL full_writes: got %0d writes %0d bad expected 16384 0", n_wr, bad_wr); end
        checks++; if (n_bursts !== 64 || n_beats !== 1024) begin errors++; $display("FAIL full_bursts: got %0d bursts %0d beats expected 64 1024", n_bursts, n_beats); end
        checks++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin errors++; $display("FAIL full_done: got %0b/%0b expected 1/1", done, core_rst_n); end
    endtask

    initial begin
        test_reset();
        test_zero_count();
        test_small_load();
        test_multi_burst();
        test_rresp_error();
        test_start_edges();
        test_async_reset();
        test_full_imem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
